mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the five-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a fixed-latency multiply or a radix-2 restoring divide.
- Holds the pipeline with a stall while busy, then presents the {HI, LO} result for one cycle with a write strobe.
- Sits beside the ALU in the execute stage and feeds the HI/LO register write path.

---
 rtl/mdu_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer for the MIPS execute stage: fixed-latency multiply and a
// radix-2 restoring divide, with the {HI, LO} result presented for one cycle with a strobe.
module mdu_sequencer #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    output logic             stall_mdu,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2((WIDTH > 16) ? WIDTH : 16);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic               stall_s;
    logic               mul_signed_s;
    logic [WIDTH-1:0]   mul_a_s, mul_b_s;
    logic [2*WIDTH-1:0] mul_a_ext_s, mul_b_ext_s, product_s;
    logic [WIDTH:0]     div_shift_s, div_trial_s;
    logic [WIDTH-1:0]   div_rem_s, div_quo_s, div_hi_s, div_lo_s;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Multiplier: live operands in the accept cycle (MUL_LAT=1), latched ones afterwards
    always_comb begin
        if (state_q == S_IDLE) begin
            mul_signed_s = ~opE[0];
            mul_a_s      = srcaE;
            mul_b_s      = srcbE;
        end else begin
            mul_signed_s = signed_q;
            mul_a_s      = a_q;
            mul_b_s      = b_q;
        end
        if (mul_signed_s) begin
            mul_a_ext_s = {{WIDTH{mul_a_s[WIDTH-1]}}, mul_a_s};
            mul_b_ext_s = {{WIDTH{mul_b_s[WIDTH-1]}}, mul_b_s};
        end else begin
            mul_a_ext_s = {{WIDTH{1'b0}}, mul_a_s};
            mul_b_ext_s = {{WIDTH{1'b0}}, mul_b_s};
        end
        product_s = mul_a_ext_s * mul_b_ext_s;
    end

    // One restoring-divide iteration on magnitudes, plus sign fix-up and divide-by-zero result
    always_comb begin
        div_shift_s = {rem_q, quo_q[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, dvs_q};
        if (div_trial_s[WIDTH]) begin
            div_rem_s = div_shift_s[WIDTH-1:0];
            div_quo_s = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            div_rem_s = div_trial_s[WIDTH-1:0];
            div_quo_s = {quo_q[WIDTH-2:0], 1'b1};
        end
        if (b_q == {WIDTH{1'b0}}) begin
            div_hi_s = a_q;
            div_lo_s = {WIDTH{1'b1}};
        end else begin
            if (signed_q && a_q[WIDTH-1]) begin
                div_hi_s = neg_f(div_rem_s);
            end else begin
                div_hi_s = div_rem_s;
            end
            if (signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) begin
                div_lo_s = neg_f(div_quo_s);
            end else begin
                div_lo_s = div_quo_s;
            end
        end
    end

    // Sequencer next-state, datapath updates and stall request
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        valid_d  = 1'b0;
        stall_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (startE && !flushE) begin
                    stall_s  = 1'b1;
                    signed_d = ~opE[0];
                    a_d      = srcaE;
                    b_d      = srcbE;
                    rem_d    = {WIDTH{1'b0}};
                    if (!opE[0] && srcaE[WIDTH-1]) begin
                        quo_d = neg_f(srcaE);
                    end else begin
                        quo_d = srcaE;
                    end
                    if (!opE[0] && srcbE[WIDTH-1]) begin
                        dvs_d = neg_f(srcbE);
                    end else begin
                        dvs_d = srcbE;
                    end
                    if (opE[1]) begin
                        state_d = S_DIV;
                        cnt_d   = CW'(WIDTH - 1);
                    end else if (MUL_LAT == 1) begin
                        state_d = S_DONE;
                        cnt_d   = {CW{1'b0}};
                        hi_d    = product_s[2*WIDTH-1:WIDTH];
                        lo_d    = product_s[WIDTH-1:0];
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_MUL;
                        cnt_d   = CW'(MUL_LAT - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                // the count includes the accept cycle, so the last MUL cycle sees 1
                stall_s = 1'b1;
                if (flushE) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (cnt_q <= CW'(1)) begin
                    state_d = S_DONE;
                    cnt_d   = {CW{1'b0}};
                    hi_d    = product_s[2*WIDTH-1:WIDTH];
                    lo_d    = product_s[WIDTH-1:0];
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                stall_s = 1'b1;
                if (flushE) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    rem_d = div_rem_s;
                    quo_d = div_quo_s;
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = S_DONE;
                        hi_d    = div_hi_s;
                        lo_d    = div_lo_s;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            signed_q <= 1'b0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            rem_q    <= {WIDTH{1'b0}};
            quo_q    <= {WIDTH{1'b0}};
            dvs_q    <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            valid_q  <= valid_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign stall_mdu    = stall_s;
    assign result_valid = valid_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: issued operations push expected {HI, LO} and
// completion cycle; a negedge monitor pops and compares on every result_valid.
module tb_mdu_sequencer;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        flushE;
    logic        stall_mdu;
    logic        result_valid;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    mdu_sequencer #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
        .flushE(flushE), .stall_mdu(stall_mdu), .result_valid(result_valid),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] last_hi   = 32'h0;
    logic [31:0] last_lo   = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model from plain 64-bit arithmetic; returns {HI, LO}
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return res;
    endfunction

    task automatic push_exp(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int done_cyc);
        logic [63:0] m;
        exp_t        e;
        m      = model(op, a, b);
        e.cyc  = done_cyc;
        e.hi   = m[63:32];
        e.lo   = m[31:0];
        e.name = name;
        sb_q.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    // Issue one op and hold startE until the instruction is released (through DONE)
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int lat, nstall, budget;
        lat    = op[1] ? WIDTH + 1 : MUL_LAT;
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        push_exp(name, op, a, b, cyc + lat);
        nstall = 0;
        budget = 0;
        @(negedge clk);
        while (stall_mdu && budget < 100) begin
            nstall++;
            budget++;
            @(negedge clk);
        end
        chk({name, "_stall_cycles"}, 64'(nstall), 64'(lat));
        @(posedge clk);
        #1;
        startE = 1'b0;
        srcaE  = $urandom;
        srcbE  = $urandom;
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (result_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result_valid", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({e.name, "_hi"}, 64'(hi_out), 64'(e.hi));
                chk({e.name, "_lo"}, 64'(lo_out), 64'(e.lo));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          sel;
        rst = 1'b0; startE = 1'b0; flushE = 1'b0; opE = 2'b00; srcaE = 32'h0; srcbE = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(result_valid), 64'd0);
        chk("reset_hi", 64'(hi_out), 64'd0);
        chk("reset_lo", 64'(lo_out), 64'd0);
        chk("reset_stall_idle", 64'(stall_mdu), 64'd0);
        @(posedge clk); #1; startE = 1'b1; opE = 2'b11; srcbE = 32'd3;
        @(negedge clk);
        chk("reset_stall_follows_start", 64'(stall_mdu), 64'd1);
        @(posedge clk); #1; flushE = 1'b1;
        @(negedge clk);
        chk("reset_stall_flush_masks", 64'(stall_mdu), 64'd0);
        @(posedge clk); #1; startE = 1'b0; flushE = 1'b0; rst = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max_x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("mult_m3_x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        run_op("div_m7_by2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_by7", 2'b11, 32'd100, 32'd7);
        run_op("divu_by_zero", 2'b11, 32'h0000_1234, 32'h0);
        run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_neg_by_zero", 2'b10, 32'hFFFF_FFFB, 32'h0);
        run_op("div_7_by_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);

        // flushE in DONE: strobe still fires
        startE = 1'b1; opE = 2'b01; srcaE = 32'h0001_0000; srcbE = 32'h0003_0000;
        push_exp("multu_flush_in_done", 2'b01, srcaE, srcbE, cyc + MUL_LAT);
        repeat (MUL_LAT) @(posedge clk);
        #1; flushE = 1'b1;
        @(negedge clk);
        chk("flush_in_done_stall", 64'(stall_mdu), 64'd0);
        @(posedge clk); #1; startE = 1'b0; flushE = 1'b0;
        @(posedge clk); #1;

        // flush mid-divide: no strobe, HI/LO held, then a MULTU completes normally
        startE = 1'b1; opE = 2'b11; srcaE = 32'd1000; srcbE = 32'd3;
        repeat (10) @(posedge clk);
        #1; flushE = 1'b1;
        @(negedge clk);
        chk("flush_div_stall_before", 64'(stall_mdu), 64'd1);
        @(posedge clk); #1; flushE = 1'b0; startE = 1'b0;
        @(negedge clk);
        chk("flush_div_stall_after", 64'(stall_mdu), 64'd0);
        chk("flush_div_hi_hold", 64'(hi_out), 64'(last_hi));
        chk("flush_div_lo_hold", 64'(lo_out), 64'(last_lo));
        @(posedge clk); #1;
        run_op("multu_after_flush", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // reset mid-multiply clears outputs and drops the operation
        startE = 1'b1; opE = 2'b00; srcaE = 32'd1234; srcbE = 32'd5678;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1; startE = 1'b0;
        @(negedge clk);
        chk("rst_mid_mul_valid", 64'(result_valid), 64'd0);
        chk("rst_mid_mul_hi", 64'(hi_out), 64'd0);
        chk("rst_mid_mul_lo", 64'(lo_out), 64'd0);
        chk("rst_mid_mul_stall", 64'(stall_mdu), 64'd0);
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'h0;
            else if (sel == 1) rb = 32'($urandom_range(1, 15));
            else if (sel == 2) rb = 32'hFFFF_FFFF;
            else rb = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op("rand_op", rop, ra, rb);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
